// File: rtl/image_viewer_pkg.sv
// Shared types for the image viewer: fill FSM encoding, RGB332 field widths
// and a helper that picks one pixel out of a packed memory word.
package image_viewer_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_FILL = 2'd2
    } fill_state_e;

    localparam int R_W    = 3;
    localparam int G_W    = 3;
    localparam int B_W    = 2;
    localparam int PIX_W  = R_W + G_W + B_W;
    localparam int WORD_W = 2 * PIX_W;

    // The first pixel on the line lives in the low byte of each word.
    function automatic logic [PIX_W-1:0] word_pixel(input logic [WORD_W-1:0] word,
                                                    input logic              hi);
        logic [PIX_W-1:0] px;
        if (hi) begin
            px = word[WORD_W-1:PIX_W];
        end else begin
            px = word[PIX_W-1:0];
        end
        return px;
    endfunction

endpackage

// File: rtl/line_bank.sv
// One line of pixel storage: synchronous write, asynchronous read.
module line_bank
    import image_viewer_pkg::*;
#(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [WORDS];

    // Contents carry no reset; a line is only read after a complete fill.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/image_line_buffer.sv
// Ping-pong line buffer: one bank is filled from memory bursts while the other
// is streamed out a pixel at a time, with the roles swapping on LineStart.
module image_line_buffer
    import image_viewer_pkg::*;
#(
    parameter int WORDS = 64,
    parameter int LINES = 96
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FrameStart,
    input  logic              LineStart,
    input  logic              PixEn,
    input  logic              WrEn,
    input  logic [WORD_W-1:0] WrData,
    output logic              FillReq,
    output logic [6:0]        FillLine,
    output logic [PIX_W-1:0]  Pixel,
    output logic              PixValid,
    output logic              Underrun
);

    localparam int              AW        = $clog2(WORDS);
    localparam int              PW        = AW + 1;
    localparam logic [PW-1:0]   PTR_END   = PW'(WORDS);
    localparam logic [PW-1:0]   PTR_LAST  = PW'(WORDS - 1);
    localparam logic [6:0]      LAST_LINE = 7'(LINES - 1);

    fill_state_e       state_q,     state_d;
    logic [PW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic              byte_sel_q,  byte_sel_d;
    logic [1:0]        full_q,      full_d;
    logic              disp_q,      disp_d;
    logic [6:0]        fill_line_q, fill_line_d;
    logic              pend_q,      pend_d;
    logic              line_ok_q,   line_ok_d;
    logic              fill_req_q,  fill_req_d;
    logic [PIX_W-1:0]  pixel_q,     pixel_d;
    logic              pix_valid_q, pix_valid_d;
    logic              underrun_q,  underrun_d;

    logic              fill_bank_s;
    logic              wr_go_s;
    logic [1:0]        bank_we_s;
    logic [WORD_W-1:0] bank_rd_s [2];
    logic [WORD_W-1:0] rd_word_s;

    assign fill_bank_s  = ~disp_q;
    assign wr_go_s      = (state_q == FILL_FILL) && WrEn && (wr_ptr_q < PTR_END) && !FrameStart;
    assign bank_we_s[0] = wr_go_s && (fill_bank_s == 1'b0);
    assign bank_we_s[1] = wr_go_s && (fill_bank_s == 1'b1);
    assign rd_word_s    = disp_q ? bank_rd_s[1] : bank_rd_s[0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank #(.WORDS(WORDS), .AW(AW)) u_bank (
            .clk     (Clk),
            .wr_en   (bank_we_s[b]),
            .wr_addr (wr_ptr_q[AW-1:0]),
            .wr_data (WrData),
            .rd_addr (rd_ptr_q[AW-1:0]),
            .rd_data (bank_rd_s[b])
        );
    end

    // Next-state logic for the fill FSM, bank swap and pixel output.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        byte_sel_d  = byte_sel_q;
        full_d      = full_q;
        disp_d      = disp_q;
        fill_line_d = fill_line_q;
        pend_d      = pend_q;
        line_ok_d   = line_ok_q;
        underrun_d  = underrun_q;
        pixel_d     = '0;
        pix_valid_d = 1'b0;

        case (state_q)
            FILL_IDLE: begin
                if (pend_q) begin
                    state_d  = FILL_REQ;
                    pend_d   = 1'b0;
                    wr_ptr_d = '0;
                end else begin
                    state_d  = FILL_IDLE;
                end
            end
            FILL_REQ: begin
                state_d = FILL_FILL;
            end
            FILL_FILL: begin
                if (wr_go_s) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (wr_ptr_q == PTR_LAST) begin
                        state_d             = FILL_IDLE;
                        full_d[fill_bank_s] = 1'b1;
                    end else begin
                        state_d = FILL_FILL;
                    end
                end else begin
                    state_d = FILL_FILL;
                end
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase

        // FrameStart outranks LineStart and any fill in flight.
        if (FrameStart) begin
            state_d     = FILL_IDLE;
            wr_ptr_d    = '0;
            full_d      = 2'b00;
            fill_line_d = 7'd0;
            pend_d      = 1'b1;
            line_ok_d   = 1'b0;
        end else if (LineStart) begin
            if (full_q[fill_bank_s]) begin
                disp_d         = fill_bank_s;
                full_d[disp_q] = 1'b0;
                rd_ptr_d       = '0;
                byte_sel_d     = 1'b0;
                line_ok_d      = 1'b1;
                if (fill_line_q < LAST_LINE) begin
                    fill_line_d = fill_line_q + 7'd1;
                    pend_d      = 1'b1;
                end else begin
                    fill_line_d = fill_line_q;
                end
            end else begin
                underrun_d = 1'b1;
                line_ok_d  = 1'b0;
            end
        end else if (PixEn && line_ok_q && (rd_ptr_q < PTR_END)) begin
            pixel_d     = word_pixel(rd_word_s, byte_sel_q);
            pix_valid_d = 1'b1;
            byte_sel_d  = ~byte_sel_q;
            if (byte_sel_q) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end else begin
            pix_valid_d = 1'b0;
        end

        fill_req_d = (state_d == FILL_REQ);
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= FILL_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            byte_sel_q  <= 1'b0;
            full_q      <= 2'b00;
            disp_q      <= 1'b0;
            fill_line_q <= 7'd0;
            pend_q      <= 1'b0;
            line_ok_q   <= 1'b0;
            fill_req_q  <= 1'b0;
            pixel_q     <= '0;
            pix_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            byte_sel_q  <= byte_sel_d;
            full_q      <= full_d;
            disp_q      <= disp_d;
            fill_line_q <= fill_line_d;
            pend_q      <= pend_d;
            line_ok_q   <= line_ok_d;
            fill_req_q  <= fill_req_d;
            pixel_q     <= pixel_d;
            pix_valid_q <= pix_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign FillReq  = fill_req_q;
    assign FillLine = fill_line_q;
    assign Pixel    = pixel_q;
    assign PixValid = pix_valid_q;
    assign Underrun = underrun_q;

endmodule

// File: tb/tb_image_line_buffer.sv
// Directed bench for image_line_buffer: expected pixels are queued as PixEn is
// driven and compared one cycle later when the DUT presents them.
module tb_image_line_buffer;
    import image_viewer_pkg::*;

    localparam int WORDS = 64;
    localparam int LINES = 96;

    logic        Clk        = 1'b0;
    logic        Reset      = 1'b1;
    logic        FrameStart = 1'b0;
    logic        LineStart  = 1'b0;
    logic        PixEn      = 1'b0;
    logic        WrEn       = 1'b0;
    logic [15:0] WrData     = 16'h0000;
    logic        FillReq;
    logic [6:0]  FillLine;
    logic [7:0]  Pixel;
    logic        PixValid;
    logic        Underrun;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] sb_q[$];
    int         freq_cnt    = 0;
    logic [6:0] freq_line   = 7'd0;

    image_line_buffer #(.WORDS(WORDS), .LINES(LINES)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .FrameStart (FrameStart),
        .LineStart  (LineStart),
        .PixEn      (PixEn),
        .WrEn       (WrEn),
        .WrData     (WrData),
        .FillReq    (FillReq),
        .FillLine   (FillLine),
        .Pixel      (Pixel),
        .PixValid   (PixValid),
        .Underrun   (Underrun)
    );

    always #5 Clk = ~Clk;

    // Count every FillReq pulse and remember the line it asked for.
    always @(negedge Clk) begin
        if (FillReq) begin
            freq_cnt  <= freq_cnt + 1;
            freq_line <= FillLine;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    function automatic logic [15:0] wd(input int line, input int i);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(17 + i + line);
        lo = 8'(i + 3 * line);
        return {hi, lo};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame();
        FrameStart = 1'b1;
        step();
        FrameStart = 1'b0;
    endtask

    task automatic pulse_line();
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
    endtask

    task automatic wait_fill(input string tag);
        int n = 0;
        while (dut.state_q != FILL_FILL && n < 40) begin
            step();
            n++;
        end
        check(tag, 32'(dut.state_q == FILL_FILL), 32'd1);
    endtask

    task automatic write_words(input int line, input int from, input int to);
        for (int i = from; i < to; i++) begin
            WrEn   = 1'b1;
            WrData = wd(line, i);
            step();
        end
        WrEn = 1'b0;
    endtask

    task automatic stream(input int n, input int line, input bit valid_line);
        logic [15:0] w;
        logic [8:0]  exp;
        logic [8:0]  got;
        for (int p = 0; p < n; p++) begin
            if (valid_line && p < 2 * WORDS) begin
                w   = wd(line, p / 2);
                exp = {1'b1, (p % 2 == 1) ? w[15:8] : w[7:0]};
            end else begin
                exp = 9'd0;
            end
            sb_q.push_back(exp);
            PixEn = 1'b1;
            step();
            got = {PixValid, Pixel};
            check($sformatf("pix L%0d #%0d", line, p), 32'(got), 32'(sb_q.pop_front()));
        end
        PixEn = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " FillReq"},  32'(FillReq),  32'd0);
        check({tag, " FillLine"}, 32'(FillLine), 32'd0);
        check({tag, " Pixel"},    32'(Pixel),    32'd0);
        check({tag, " PixValid"}, 32'(PixValid), 32'd0);
        check({tag, " Underrun"}, 32'(Underrun), 32'd0);
    endtask

    initial begin
        int base;

        // Reset state.
        Reset = 1'b1;
        repeat (3) step();
        check_outputs_zero("reset");
        Reset = 1'b0;
        step();

        // FrameStart issues exactly one request for line 0.
        base = freq_cnt;
        pulse_frame();
        repeat (4) step();
        check("frame req count", 32'(freq_cnt - base), 32'd1);
        check("frame req line",  32'(freq_line), 32'd0);
        check("frame FillLine",  32'(FillLine),  32'd0);
        wait_fill("frame in FILL");

        // Full line 0, then display it with one tick past the end.
        write_words(0, 0, WORDS);
        pulse_line();
        stream(2 * WORDS + 1, 0, 1'b1);
        check("line1 req count", 32'(freq_cnt - base), 32'd2);
        check("line1 req line",  32'(freq_line), 32'd1);
        check("no underrun yet", 32'(Underrun),  32'd0);

        // Line 1 only partly filled when LineStart arrives.
        wait_fill("line1 in FILL");
        write_words(1, 0, 10);
        pulse_line();
        check("underrun set",       32'(Underrun), 32'd1);
        check("underrun FillLine",  32'(FillLine), 32'd1);
        stream(8, 1, 1'b0);
        write_words(1, 10, WORDS);
        pulse_line();
        stream(2 * WORDS + 1, 1, 1'b1);
        check("underrun sticky", 32'(Underrun), 32'd1);

        // Remaining lines of the frame; the last one requests nothing more.
        for (int l = 2; l < LINES; l++) begin
            wait_fill($sformatf("line%0d in FILL", l));
            write_words(l, 0, WORDS);
            pulse_line();
            stream(4, l, 1'b1);
        end
        repeat (20) step();
        check("frame total reqs", 32'(freq_cnt - base), 32'(LINES));
        check("last FillLine",    32'(FillLine), 32'(LINES - 1));
        check("idle after frame", 32'(dut.state_q == FILL_IDLE), 32'd1);

        // New frame restarts at line 0.
        base = freq_cnt;
        pulse_frame();
        repeat (4) step();
        check("refrm req count", 32'(freq_cnt - base), 32'd1);
        check("refrm req line",  32'(freq_line), 32'd0);
        check("refrm FillLine",  32'(FillLine),  32'd0);

        // FrameStart and LineStart together with a full fill bank.
        wait_fill("pre-coll in FILL");
        write_words(5, 0, WORDS);
        step();
        base       = freq_cnt;
        FrameStart = 1'b1;
        LineStart  = 1'b1;
        step();
        FrameStart = 1'b0;
        LineStart  = 1'b0;
        stream(4, 5, 1'b0);
        check("coll req count", 32'(freq_cnt - base), 32'd1);
        check("coll req line",  32'(freq_line), 32'd0);
        check("coll FillLine",  32'(FillLine),  32'd0);
        pulse_line();
        stream(2, 5, 1'b0);
        check("coll FillLine kept", 32'(FillLine), 32'd0);
        wait_fill("post-coll in FILL");
        write_words(6, 0, WORDS);
        pulse_line();
        stream(4, 6, 1'b1);
        check("post-coll FillLine", 32'(FillLine), 32'd1);

        // Reset in the middle of a fill, then a clean restart.
        wait_fill("pre-reset in FILL");
        write_words(7, 0, 30);
        Reset = 1'b1;
        step();
        check_outputs_zero("mid-fill reset");
        step();
        Reset = 1'b0;
        step();
        base = freq_cnt;
        pulse_frame();
        repeat (4) step();
        check("rst req count", 32'(freq_cnt - base), 32'd1);
        check("rst req line",  32'(freq_line), 32'd0);
        wait_fill("rst in FILL");
        write_words(9, 0, WORDS);
        pulse_line();
        stream(2 * WORDS + 1, 9, 1'b1);
        check("rst Underrun clear", 32'(Underrun), 32'd0);
        check("rst FillLine",       32'(FillLine), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
